// File: rtl/thread_regfile.sv
// Per-thread register file: sixteen DATA_BITS registers feeding the ALU/LSU operands.
// R13..R15 are read-only thread identity registers (block index, block size, thread id).
module thread_regfile #(
    parameter int THREAD_ID         = 0,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic [7:0]           block_id,
    input  logic [3:0]           rd_addr,
    input  logic [3:0]           rs_addr,
    input  logic [3:0]           rt_addr,
    input  logic                 reg_write_enable,
    input  logic [1:0]           reg_input_mux,
    input  logic [DATA_BITS-1:0] immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs_out,
    output logic [DATA_BITS-1:0] rt_out
);

    localparam logic [2:0] STATE_REQUEST = 3'b011;
    localparam logic [2:0] STATE_UPDATE  = 3'b110;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_LSU  = 2'b01;
    localparam logic [1:0] MUX_IMM  = 2'b10;

    localparam logic [3:0] FIRST_READ_ONLY = 4'd13;

    logic [DATA_BITS-1:0] regs [0:15];
    logic [DATA_BITS-1:0] write_data;
    logic                 write_valid;

    always_comb begin
        write_data  = '0;
        write_valid = 1'b0;
        case (reg_input_mux)
            MUX_ALU: begin
                write_data  = alu_out;
                write_valid = 1'b1;
            end
            MUX_LSU: begin
                write_data  = lsu_out;
                write_valid = 1'b1;
            end
            MUX_IMM: begin
                write_data  = immediate;
                write_valid = 1'b1;
            end
            default: begin
                write_data  = '0;
                write_valid = 1'b0;
            end
        endcase
    end

    // Reads and writes live in different core states, so no write-to-read bypass is needed.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 13; i++) begin
                regs[i] <= '0;
            end
            regs[13] <= '0;
            regs[14] <= DATA_BITS'(THREADS_PER_BLOCK);
            regs[15] <= DATA_BITS'(THREAD_ID);
            rs_out   <= '0;
            rt_out   <= '0;
        end else if (enable) begin
            regs[13] <= DATA_BITS'(block_id);
            if (core_state == STATE_REQUEST) begin
                rs_out <= regs[rs_addr];
                rt_out <= regs[rt_addr];
            end
            if (core_state == STATE_UPDATE && reg_write_enable && write_valid
                && rd_addr < FIRST_READ_ONLY) begin
                regs[rd_addr] <= write_data;
            end
        end
    end

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile: a table of write/read vectors plus hand-written
// sequences for reset, state gating, enable hold and R13 lag.
module tb_thread_regfile;

    localparam int THREAD_ID         = 2;
    localparam int THREADS_PER_BLOCK = 4;
    localparam int DATA_BITS         = 8;
    localparam int W                 = 2 * DATA_BITS;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;

    logic                 clock;
    logic                 reset;
    logic                 enable;
    logic [2:0]           core_state;
    logic [7:0]           block_id;
    logic [3:0]           rd_addr;
    logic [3:0]           rs_addr;
    logic [3:0]           rt_addr;
    logic                 reg_write_enable;
    logic [1:0]           reg_input_mux;
    logic [DATA_BITS-1:0] immediate;
    logic [DATA_BITS-1:0] alu_out;
    logic [DATA_BITS-1:0] lsu_out;
    logic [DATA_BITS-1:0] rs_out;
    logic [DATA_BITS-1:0] rt_out;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q [$];

    thread_regfile #(
        .THREAD_ID(THREAD_ID),
        .THREADS_PER_BLOCK(THREADS_PER_BLOCK),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .core_state(core_state),
        .block_id(block_id),
        .rd_addr(rd_addr),
        .rs_addr(rs_addr),
        .rt_addr(rt_addr),
        .reg_write_enable(reg_write_enable),
        .reg_input_mux(reg_input_mux),
        .immediate(immediate),
        .alu_out(alu_out),
        .lsu_out(lsu_out),
        .rs_out(rs_out),
        .rt_out(rt_out)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       is_write;
        logic [3:0] rd;
        logic [1:0] mux;
        logic [7:0] val;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [7:0] exp_rs;
        logic [7:0] exp_rt;
        string      name;
    } vec_t;

    vec_t vecs [$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got rs/rt=%h expected %h", name, act, exp);
        end
    endtask

    // Puts distinct values on every source so only the selected one can land in the register.
    task automatic do_write(input logic [2:0] st, input logic [3:0] rd, input logic [1:0] mux,
                            input logic [7:0] val);
        core_state       = st;
        rd_addr          = rd;
        reg_input_mux    = mux;
        reg_write_enable = 1'b1;
        alu_out          = (mux == 2'b00) ? val : ~val;
        lsu_out          = (mux == 2'b01) ? val : (val ^ 8'h5A);
        immediate        = (mux == 2'b10) ? val : (val ^ 8'hC3);
        tick();
        reg_write_enable = 1'b0;
        core_state       = S_IDLE;
    endtask

    task automatic read_check(input string name, input logic [3:0] rs, input logic [3:0] rt,
                              input logic [7:0] ers, input logic [7:0] ert);
        logic [W-1:0] exp;
        exp_q.push_back({ers, ert});
        core_state = S_REQUEST;
        rs_addr    = rs;
        rt_addr    = rt;
        tick();
        core_state = S_WAIT;
        exp = exp_q.pop_front();
        check(name, {rs_out, rt_out}, exp);
    endtask

    function automatic void add_w(input string n, input logic [3:0] rd, input logic [1:0] mux,
                                  input logic [7:0] val);
        vec_t v;
        v.is_write = 1'b1; v.rd = rd; v.mux = mux; v.val = val;
        v.rs = '0; v.rt = '0; v.exp_rs = '0; v.exp_rt = '0; v.name = n;
        vecs.push_back(v);
    endfunction

    function automatic void add_r(input string n, input logic [3:0] rs, input logic [3:0] rt,
                                  input logic [7:0] ers, input logic [7:0] ert);
        vec_t v;
        v.is_write = 1'b0; v.rd = '0; v.mux = '0; v.val = '0;
        v.rs = rs; v.rt = rt; v.exp_rs = ers; v.exp_rt = ert; v.name = n;
        vecs.push_back(v);
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b1; core_state = S_IDLE; block_id = 8'd9;
        rd_addr = '0; rs_addr = '0; rt_addr = '0; reg_write_enable = 1'b0;
        reg_input_mux = 2'b11; immediate = '0; alu_out = '0; lsu_out = '0;

        add_r("reset_ids",   4'd15, 4'd14, 8'd2,  8'd4);
        add_w("w_alu_r3",    4'd3,  2'b00, 8'h5A);
        add_r("rd_alu_r3",   4'd3,  4'd0,  8'h5A, 8'h00);
        add_w("w_lsu_r5",    4'd5,  2'b01, 8'h81);
        add_r("rd_lsu_r5",   4'd5,  4'd6,  8'h81, 8'h00);
        add_w("w_imm_r6",    4'd6,  2'b10, 8'h07);
        add_r("rd_imm_r6",   4'd6,  4'd6,  8'h07, 8'h07);
        add_w("w_none_r7",   4'd7,  2'b11, 8'h99);
        add_r("rd_none_r7",  4'd7,  4'd5,  8'h00, 8'h81);
        add_w("w_r14",       4'd14, 2'b00, 8'hFF);
        add_w("w_r15",       4'd15, 2'b10, 8'hFF);
        add_w("w_r13",       4'd13, 2'b01, 8'hFF);
        add_r("rd_ro_ids",   4'd15, 4'd14, 8'd2,  8'd4);
        add_r("rd_r13_blk",  4'd13, 4'd3,  8'd9,  8'h5A);
        add_w("w_r12",       4'd12, 2'b00, 8'hC3);
        add_r("rd_r12_r0",   4'd12, 4'd0,  8'hC3, 8'h00);

        // Reset held for two cycles
        tick();
        tick();
        check("reset_outputs", {rs_out, rt_out}, 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_write)
                do_write(S_UPDATE, vecs[i].rd, vecs[i].mux, vecs[i].val);
            else
                read_check(vecs[i].name, vecs[i].rs, vecs[i].rt, vecs[i].exp_rs, vecs[i].exp_rt);
        end

        // Write request outside UPDATE is ignored
        do_write(S_EXECUTE, 4'd1, 2'b00, 8'h33);
        read_check("wr_in_execute", 4'd1, 4'd1, 8'h00, 8'h00);

        // Operands hold through WAIT/EXECUTE while addresses change
        read_check("hold_latch", 4'd3, 4'd5, 8'h5A, 8'h81);
        rs_addr = 4'd6; rt_addr = 4'd7; core_state = S_WAIT;
        tick();
        check("hold_wait", {rs_out, rt_out}, {8'h5A, 8'h81});
        core_state = S_EXECUTE;
        tick();
        check("hold_execute", {rs_out, rt_out}, {8'h5A, 8'h81});

        // Enable low freezes outputs, registers and R13
        do_write(S_UPDATE, 4'd2, 2'b00, 8'h44);
        read_check("r2_before", 4'd2, 4'd2, 8'h44, 8'h44);
        enable = 1'b0;
        block_id = 8'h21;
        core_state = S_REQUEST; rs_addr = 4'd3; rt_addr = 4'd5;
        tick();
        check("dis_request", {rs_out, rt_out}, {8'h44, 8'h44});
        do_write(S_UPDATE, 4'd2, 2'b00, 8'h55);
        check("dis_update", {rs_out, rt_out}, {8'h44, 8'h44});
        enable = 1'b1;
        // The first enabled edge reads R13 while loading the new block_id.
        read_check("r13_lag", 4'd13, 4'd2, 8'd9, 8'h44);
        read_check("r13_new", 4'd13, 4'd13, 8'h21, 8'h21);

        // Reset during EXECUTE discards operands and register contents
        do_write(S_UPDATE, 4'd4, 2'b00, 8'h11);
        read_check("r4_latch", 4'd4, 4'd4, 8'h11, 8'h11);
        core_state = S_EXECUTE;
        reset = 1'b1;
        tick();
        check("reset_mid_op", {rs_out, rt_out}, 16'h0000);
        reset = 1'b0;
        read_check("post_reset_r4_r13", 4'd4, 4'd13, 8'h00, 8'h00);
        read_check("post_reset_r3_r2",  4'd3, 4'd2,  8'h00, 8'h00);
        read_check("post_reset_ids",    4'd14, 4'd15, 8'd4, 8'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
